// File: rtl/pe_mem_port_arbiter_if.sv
// Request/grant, read-return and SRAM-side signals of the PE memory port arbiter.
// slave = arbiter side, master = requester/SRAM environment side.
interface pe_mem_port_arbiter_if #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64
);
    logic [NUM_LANES-1:0]        dma__arb__valid;
    logic [NUM_LANES*ADDR_W-1:0] dma__arb__addr;
    logic [NUM_LANES-1:0]        arb__dma__ready;
    logic [NUM_LANES-1:0]        arb__dma__rd_valid;
    logic [DATA_W-1:0]           arb__dma__rd_data;

    logic                        ls__arb__valid;
    logic                        ls__arb__write;
    logic [ADDR_W-1:0]           ls__arb__addr;
    logic [DATA_W-1:0]           ls__arb__wdata;
    logic                        arb__ls__ready;
    logic                        arb__ls__rd_valid;
    logic [DATA_W-1:0]           arb__ls__rd_data;

    logic                        arb__sram__en;
    logic                        arb__sram__we;
    logic [ADDR_W-1:0]           arb__sram__addr;
    logic [DATA_W-1:0]           arb__sram__wdata;
    logic [DATA_W-1:0]           sram__arb__rdata;

    modport slave (
        input  dma__arb__valid, dma__arb__addr,
        input  ls__arb__valid, ls__arb__write, ls__arb__addr, ls__arb__wdata,
        input  sram__arb__rdata,
        output arb__dma__ready, arb__dma__rd_valid, arb__dma__rd_data,
        output arb__ls__ready, arb__ls__rd_valid, arb__ls__rd_data,
        output arb__sram__en, arb__sram__we, arb__sram__addr, arb__sram__wdata
    );

    modport master (
        output dma__arb__valid, dma__arb__addr,
        output ls__arb__valid, ls__arb__write, ls__arb__addr, ls__arb__wdata,
        output sram__arb__rdata,
        input  arb__dma__ready, arb__dma__rd_valid, arb__dma__rd_data,
        input  arb__ls__ready, arb__ls__rd_valid, arb__ls__rd_data,
        input  arb__sram__en, arb__sram__we, arb__sram__addr, arb__sram__wdata
    );
endinterface

// File: rtl/pe_mem_port_arbiter.sv
// Single SRAM port shared by NUM_LANES DMA read streams and one load/store unit:
// bounded LS priority, round-robin DMA, fixed-latency read return via tag pipeline.
module pe_mem_port_arbiter #(
    parameter int NUM_LANES    = 4,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 64,
    parameter int RD_LAT       = 2,
    parameter int LS_MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    pe_mem_port_arbiter_if.slave      bus
);
    localparam int          LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int          CNT_W  = $clog2(LS_MAX_BURST + 1);
    localparam int unsigned NL     = NUM_LANES;

    typedef struct packed {
        logic              valid;
        logic              is_ls;
        logic [LANE_W-1:0] lane;
    } tag_t;

    tag_t              tag_pipe [RD_LAT];
    tag_t              ret;
    logic [LANE_W-1:0] rr_ptr;
    logic [CNT_W-1:0]  ls_burst_cnt;
    logic              any_dma;
    logic              ls_grant;
    logic              dma_grant;
    logic [LANE_W-1:0] dma_lane;
    int unsigned       idx;

    // Grant decision; reset forces every grant low so outputs read 0 during reset.
    always_comb begin
        any_dma   = |bus.dma__arb__valid;
        ls_grant  = !reset_poweron && bus.ls__arb__valid &&
                    (!any_dma || (ls_burst_cnt < CNT_W'(LS_MAX_BURST)));
        dma_grant = 1'b0;
        dma_lane  = '0;
        idx       = 0;
        if (!reset_poweron && !ls_grant) begin
            for (int unsigned k = 0; k < NL; k++) begin
                idx = (32'(rr_ptr) + k) % NL;
                if (!dma_grant && bus.dma__arb__valid[idx]) begin
                    dma_grant = 1'b1;
                    dma_lane  = LANE_W'(idx);
                end
            end
        end
    end

    always_comb begin
        bus.arb__ls__ready   = ls_grant;
        bus.arb__dma__ready  = dma_grant ? (NUM_LANES'(1) << dma_lane) : '0;
        bus.arb__sram__en    = ls_grant | dma_grant;
        bus.arb__sram__we    = ls_grant & bus.ls__arb__write;
        bus.arb__sram__addr  = '0;
        bus.arb__sram__wdata = '0;
        if (ls_grant) begin
            bus.arb__sram__addr  = bus.ls__arb__addr;
            bus.arb__sram__wdata = bus.ls__arb__wdata;
        end else if (dma_grant) begin
            bus.arb__sram__addr  = bus.dma__arb__addr[dma_lane*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            rr_ptr       <= '0;
            ls_burst_cnt <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            if (dma_grant) begin
                rr_ptr <= (dma_lane == LANE_W'(NUM_LANES - 1)) ? '0 : dma_lane + 1'b1;
            end
            if (dma_grant || !any_dma) begin
                ls_burst_cnt <= '0;
            end else if (ls_grant && (ls_burst_cnt < CNT_W'(LS_MAX_BURST))) begin
                ls_burst_cnt <= ls_burst_cnt + 1'b1;
            end
            // Stores occupy a slot with valid=0 so read returns stay aligned to SRAM latency.
            tag_pipe[0].valid <= dma_grant | (ls_grant & ~bus.ls__arb__write);
            tag_pipe[0].is_ls <= ls_grant;
            tag_pipe[0].lane  <= dma_lane;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    always_comb begin
        ret                    = tag_pipe[RD_LAT-1];
        bus.arb__ls__rd_valid  = !reset_poweron && ret.valid && ret.is_ls;
        bus.arb__ls__rd_data   = bus.arb__ls__rd_valid ? bus.sram__arb__rdata : '0;
        bus.arb__dma__rd_valid = '0;
        bus.arb__dma__rd_data  = '0;
        if (!reset_poweron && ret.valid && !ret.is_ls) begin
            bus.arb__dma__rd_valid = NUM_LANES'(1) << ret.lane;
            bus.arb__dma__rd_data  = bus.sram__arb__rdata;
        end
    end
endmodule

// File: tb/tb_pe_mem_port_arbiter.sv
// Randomized and directed bench for pe_mem_port_arbiter against a queue-based
// behavioural model of arbitration and fixed-latency read return.
module tb_pe_mem_port_arbiter;
    localparam int NL  = 4;
    localparam int AW  = 16;
    localparam int DW  = 64;
    localparam int LAT = 2;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset_poweron;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pe_mem_port_arbiter_if #(.NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW)) bus ();

    pe_mem_port_arbiter #(
        .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .LS_MAX_BURST(MAXB)
    ) dut (
        .clk(clk),
        .reset_poweron(reset_poweron),
        .bus(bus)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a, ~a, a ^ 16'h5a5a, a + 16'h1234};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // SRAM environment: RD_LAT-cycle read latency, write commits at the clock edge
    logic [DW-1:0] sram_mem [logic [AW-1:0]];
    logic [DW-1:0] sram_pipe [LAT];
    assign bus.sram__arb__rdata = sram_pipe[LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) sram_pipe[i] <= sram_pipe[i-1];
        if (bus.arb__sram__en && !bus.arb__sram__we)
            sram_pipe[0] <= sram_mem.exists(bus.arb__sram__addr) ?
                            sram_mem[bus.arb__sram__addr] : init_word(bus.arb__sram__addr);
        else
            sram_pipe[0] <= '0;
        if (bus.arb__sram__en && bus.arb__sram__we)
            sram_mem[bus.arb__sram__addr] = bus.arb__sram__wdata;
    end

    // Behavioural model: arbitration rules plus a queue of expected returns
    typedef struct {
        longint        due;
        bit            is_ls;
        int            lane;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq [$];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    int            m_rr = 0;
    int            m_cnt = 0;
    longint        cyc = 0;

    always @(negedge clk) begin
        bit            anyd, exp_ls, exp_we, exp_en, ret_now;
        int            exp_lane;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_rd;
        ret_t          r;
        anyd     = |bus.dma__arb__valid;
        exp_ls   = 0;
        exp_lane = -1;
        if (!reset_poweron) begin
            if (bus.ls__arb__valid && (!anyd || m_cnt < MAXB)) exp_ls = 1;
            else if (anyd)
                for (int i = 0; i < NL; i++)
                    if (exp_lane < 0 && bus.dma__arb__valid[(m_rr + i) % NL]) exp_lane = (m_rr + i) % NL;
        end
        exp_en   = exp_ls || exp_lane >= 0;
        exp_we   = exp_ls && bus.ls__arb__write;
        exp_addr = exp_ls ? bus.ls__arb__addr :
                   (exp_lane >= 0) ? bus.dma__arb__addr[exp_lane*AW +: AW] : '0;
        check("ls_ready", DW'(bus.arb__ls__ready), DW'(exp_ls));
        check("dma_ready", DW'(bus.arb__dma__ready), (exp_lane >= 0) ? DW'(1) << exp_lane : '0);
        check("sram_en", DW'(bus.arb__sram__en), DW'(exp_en));
        check("sram_we", DW'(bus.arb__sram__we), DW'(exp_we));
        check("sram_addr", DW'(bus.arb__sram__addr), DW'(exp_addr));
        if (!exp_en) check("sram_wdata_idle", bus.arb__sram__wdata, '0);
        else if (exp_we) check("sram_wdata", bus.arb__sram__wdata, bus.ls__arb__wdata);

        ret_now = !reset_poweron && rq.size() > 0 && rq[0].due == cyc;
        if (ret_now) r = rq.pop_front();
        exp_rd = ret_now ? r.data : '0;
        check("ls_rd_valid", DW'(bus.arb__ls__rd_valid), DW'(ret_now && r.is_ls));
        check("ls_rd_data", bus.arb__ls__rd_data, (ret_now && r.is_ls) ? exp_rd : '0);
        check("dma_rd_valid", DW'(bus.arb__dma__rd_valid),
              (ret_now && !r.is_ls) ? DW'(1) << r.lane : '0);
        check("dma_rd_data", bus.arb__dma__rd_data, (ret_now && !r.is_ls) ? exp_rd : '0);

        if (reset_poweron) begin
            m_rr = 0;
            m_cnt = 0;
            rq.delete();
        end else begin
            if (exp_lane >= 0) begin
                m_rr  = (exp_lane + 1) % NL;
                m_cnt = 0;
            end else if (!anyd) m_cnt = 0;
            else if (exp_ls && m_cnt < MAXB) m_cnt++;
            if (exp_we) model_mem[exp_addr] = bus.ls__arb__wdata;
            else if (exp_en) begin
                r.due   = cyc + LAT;
                r.is_ls = exp_ls;
                r.lane  = exp_lane;
                r.data  = model_mem.exists(exp_addr) ? model_mem[exp_addr] : init_word(exp_addr);
                rq.push_back(r);
            end
        end
        cyc++;
    end

    task automatic idle_inputs();
        bus.dma__arb__valid = '0;
        bus.dma__arb__addr  = '0;
        bus.ls__arb__valid  = 1'b0;
        bus.ls__arb__write  = 1'b0;
        bus.ls__arb__addr   = '0;
        bus.ls__arb__wdata  = '0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset_poweron = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        reset_poweron = 1'b0;
    endtask

    initial begin
        reset_poweron = 1'b1;
        bus.dma__arb__valid = '1;
        bus.dma__arb__addr  = '0;
        bus.ls__arb__valid  = 1'b1;
        bus.ls__arb__write  = 1'b0;
        bus.ls__arb__addr   = '0;
        bus.ls__arb__wdata  = '0;
        #2;
        check("reset_ls_ready", DW'(bus.arb__ls__ready), '0);
        check("reset_dma_ready", DW'(bus.arb__dma__ready), '0);
        check("reset_sram_en", DW'(bus.arb__sram__en), '0);
        pulse_reset();

        // Only lane 2 valid for three cycles
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            bus.dma__arb__valid = (c < 3) ? 4'b0100 : 4'b0000;
            bus.dma__arb__addr  = (c < 3) ? 64'h0000_0010_0000_0000 : '0;
            #1;
            if (c < 3) check("l2_ready", DW'(bus.arb__dma__ready), DW'(4'b0100));
            if (c >= 2) begin
                check("l2_rd_valid", DW'(bus.arb__dma__rd_valid), DW'(4'b0100));
                check("l2_rd_data", bus.arb__dma__rd_data, init_word(16'h0010));
            end
        end

        // All lanes valid, LS idle: strict rotation from lane 0
        pulse_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            bus.dma__arb__valid = '1;
            bus.dma__arb__addr  = 64'h0103_0102_0101_0100;
            #1;
            check("rr_grant", DW'(bus.arb__dma__ready), DW'(1) << (c % 4));
        end

        // LS and all lanes valid: four LS grants then one DMA grant, repeating
        pulse_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus.dma__arb__valid = '1;
            bus.dma__arb__addr  = 64'h0007_0006_0005_0004;
            bus.ls__arb__valid  = 1'b1;
            bus.ls__arb__addr   = 16'h0008;
            #1;
            check("burst_ls", DW'(bus.arb__ls__ready), DW'((c % 5) < 4));
            check("burst_dma", DW'(bus.arb__dma__ready), ((c % 5) < 4) ? '0 : DW'(1) << ((c / 5) % 4));
        end

        // Store then load of the same address
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (c < 2) begin
                bus.ls__arb__valid = 1'b1;
                bus.ls__arb__write = (c == 0);
                bus.ls__arb__addr  = 16'h0100;
                bus.ls__arb__wdata = (c == 0) ? 64'hDEAD_BEEF : '0;
            end
            #1;
            if (c == 0) check("store_we", DW'(bus.arb__sram__we), DW'(1));
            if (c == 2) check("store_no_rd", DW'(bus.arb__ls__rd_valid), '0);
            if (c == 3) begin
                check("raw_rd_valid", DW'(bus.arb__ls__rd_valid), DW'(1));
                check("raw_rd_data", bus.arb__ls__rd_data, 64'hDEAD_BEEF);
            end
        end

        // Lane 1 read in flight when reset hits
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            reset_poweron = (c == 1);
            if (c == 0) begin
                bus.dma__arb__valid = 4'b0010;
                bus.dma__arb__addr  = 64'h0000_0000_0020_0000;
            end else if (c == 1) begin
                bus.dma__arb__valid = '1;
                bus.ls__arb__valid  = 1'b1;
            end
            #1;
            if (c == 0) check("l1_ready", DW'(bus.arb__dma__ready), DW'(4'b0010));
            if (c == 1) begin
                check("rst_dma_ready", DW'(bus.arb__dma__ready), '0);
                check("rst_ls_ready", DW'(bus.arb__ls__ready), '0);
                check("rst_sram_addr", DW'(bus.arb__sram__addr), '0);
            end
            if (c >= 1) check("rst_dropped_rd", DW'(bus.arb__dma__rd_valid), '0);
        end

        // LS load then lane 3 read: returns in grant order
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (c == 0) begin
                bus.ls__arb__valid = 1'b1;
                bus.ls__arb__addr  = 16'h0200;
            end else if (c == 1) begin
                bus.dma__arb__valid = 4'b1000;
                bus.dma__arb__addr  = 64'h0300_0000_0000_0000;
            end
            #1;
            if (c == 2) begin
                check("mix_ls_rdv", DW'(bus.arb__ls__rd_valid), DW'(1));
                check("mix_ls_rdd", bus.arb__ls__rd_data, init_word(16'h0200));
                check("mix_dma_none", DW'(bus.arb__dma__rd_valid), '0);
            end
            if (c == 3) begin
                check("mix_dma_rdv", DW'(bus.arb__dma__rd_valid), DW'(4'b1000));
                check("mix_dma_rdd", bus.arb__dma__rd_data, init_word(16'h0300));
                check("mix_ls_none", DW'(bus.arb__ls__rd_valid), '0);
            end
        end

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset_poweron = ($urandom_range(0, 299) == 0);
            bus.dma__arb__valid = 4'($urandom);
            if ((c % 600) < 300) bus.dma__arb__valid = bus.dma__arb__valid & 4'($urandom);
            for (int l = 0; l < NL; l++) bus.dma__arb__addr[l*AW +: AW] = 16'($urandom_range(0, 31));
            bus.ls__arb__valid = ($urandom_range(0, 2) != 0);
            bus.ls__arb__write = ($urandom_range(0, 2) == 0);
            bus.ls__arb__addr  = 16'($urandom_range(0, 31));
            bus.ls__arb__wdata = {$urandom, $urandom};
        end

        @(posedge clk); #1;
        reset_poweron = 1'b0;
        idle_inputs();
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
